// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: recovers pixel coordinates, active video, lock and sticky error status from the VGA pins.
// Define RX_CHECKSUM_EN to build the per-frame rgb checksum; otherwise frame_sum is tied to zero.

module vga_rx_monitor #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SYNC_NEG    = 1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_tick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb,
  output logic [9:0]  x_rx,
  output logic [9:0]  y_rx,
  output logic        de_rx,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic        frame_done,
  output logic [15:0] frame_sum
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int GOOD_W  = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);

  localparam logic [10:0]       H_TOTAL_C = 11'(H_TOTAL);
  localparam logic [10:0]       V_TOTAL_C = 11'(V_TOTAL);
  localparam logic [9:0]        H_DE_LO   = 10'(H_SYNC + H_BP);
  localparam logic [9:0]        H_DE_HI   = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0]        V_DE_LO   = 10'(V_SYNC + V_BP);
  localparam logic [9:0]        V_DE_HI   = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0]        CNT_MAX   = 10'h3FF;
  localparam logic [GOOD_W-1:0] GOOD_FULL = GOOD_W'(LOCK_FRAMES);

  // Sync polarity normalised so that 1 always means "sync active".
  logic hs_act;
  logic vs_act;
  assign hs_act = (SYNC_NEG != 0) ? ~hsync : hsync;
  assign vs_act = (SYNC_NEG != 0) ? ~vsync : vsync;

  logic              hs_prev_q;
  logic              vs_prev_q;
  logic [9:0]        hcnt_q, hcnt_d;
  logic [9:0]        vcnt_q, vcnt_d;
  logic              h_seen_q, h_seen_d;
  logic              v_seen_q, v_seen_d;
  logic              v_pend_q, v_pend_d;
  logic              frame_bad_q, frame_bad_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic              h_err_q, h_err_d;
  logic              v_err_q, v_err_d;
  logic              locked_q, locked_d;
  logic              de_q, de_d;
  logic [9:0]        x_q, x_d;
  logic [9:0]        y_q, y_d;
  logic              frame_done_q;

  logic        h_edge;
  logic        v_edge;
  logic        boundary;
  logic        report;
  logic        h_mis;
  logic        v_mis;
  logic [10:0] hcnt_inc;
  logic [10:0] vcnt_inc;

  assign h_edge   = hs_act & ~hs_prev_q;
  assign v_edge   = vs_act & ~vs_prev_q;
  // A vsync edge landing on the same tick as the hsync edge closes the frame immediately.
  assign boundary = h_edge & (v_pend_q | v_edge);
  assign report   = boundary & v_seen_q;
  assign hcnt_inc = {1'b0, hcnt_q} + 11'd1;
  assign vcnt_inc = {1'b0, vcnt_q} + 11'd1;
  assign h_mis    = h_edge & h_seen_q & (hcnt_inc != H_TOTAL_C);
  assign v_mis    = report & (vcnt_inc != V_TOTAL_C);

  always_comb begin : h_track
    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    hcnt_d   = hcnt_q;
    h_seen_d = h_seen_q;
    if (h_edge) begin
      hcnt_d   = '0;
      h_seen_d = 1'b1;
    end else if (hcnt_q != CNT_MAX) begin
      hcnt_d = hcnt_q + 10'd1;
    end
  end

  always_comb begin : v_track
    vcnt_d   = vcnt_q;
    v_pend_d = v_pend_q;
    v_seen_d = v_seen_q;
    if (boundary) begin
      vcnt_d   = '0;
      v_pend_d = 1'b0;
      v_seen_d = 1'b1;
    end else begin
      if (v_edge) begin
        v_pend_d = 1'b1;
      end
      if (h_edge && (vcnt_q != CNT_MAX)) begin
        vcnt_d = vcnt_q + 10'd1;
      end
    end
  end

  always_comb begin : status
    h_err_d     = h_err_q | h_mis;
    v_err_d     = v_err_q | v_mis;
    frame_bad_d = boundary ? 1'b0 : (frame_bad_q | h_mis);
    good_d      = good_q;
    if (h_mis || v_mis) begin
      good_d = '0;
    end else if (report && !frame_bad_q && (good_q != GOOD_FULL)) begin
      good_d = good_q + 1'b1;
    end
    locked_d = (good_d == GOOD_FULL);
  end

  // Outputs describe the pixel sampled at this tick, so decode uses the next-state counters.
  always_comb begin : decode
    de_d = v_seen_d
         && (hcnt_d >= H_DE_LO) && (hcnt_d < H_DE_HI)
         && (vcnt_d >= V_DE_LO) && (vcnt_d < V_DE_HI);
    x_d  = '0;
    y_d  = '0;
    if (de_d) begin
      x_d = hcnt_d - H_DE_LO;
      y_d = vcnt_d - V_DE_LO;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and takes priority over pix_tick, so a reset clk clears state even between ticks.
    if (reset) begin
      hs_prev_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      h_seen_q     <= 1'b0;
      v_seen_q     <= 1'b0;
      v_pend_q     <= 1'b0;
      frame_bad_q  <= 1'b0;
      good_q       <= '0;
      h_err_q      <= 1'b0;
      v_err_q      <= 1'b0;
      locked_q     <= 1'b0;
      de_q         <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values computed above.
      frame_done_q <= pix_tick & report;
      if (pix_tick) begin
        hs_prev_q   <= hs_act;
        vs_prev_q   <= vs_act;
        hcnt_q      <= hcnt_d;
        vcnt_q      <= vcnt_d;
        h_seen_q    <= h_seen_d;
        v_seen_q    <= v_seen_d;
        v_pend_q    <= v_pend_d;
        frame_bad_q <= frame_bad_d;
        good_q      <= good_d;
        h_err_q     <= h_err_d;
        v_err_q     <= v_err_d;
        locked_q    <= locked_d;
        de_q        <= de_d;
        x_q         <= x_d;
        y_q         <= y_d;
      end
    end
  end

`ifdef RX_CHECKSUM_EN
  logic [15:0] acc_q, acc_d;
  logic [15:0] sum_q, sum_d;

  always_comb begin : checksum
    acc_d = acc_q;
    sum_d = sum_q;
    if (report) begin
      sum_d = acc_q;
    end
    if (boundary) begin
      acc_d = '0;
    end else if (de_d) begin
      acc_d = {acc_q[14:0], acc_q[15]} ^ {4'b0000, rgb};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      sum_q <= '0;
    end else if (pix_tick) begin
      acc_q <= acc_d;
      sum_q <= sum_d;
    end
  end

  assign frame_sum = sum_q;
`else
  logic unused_rgb;
  assign unused_rgb = ^rgb;
  assign frame_sum  = '0;
`endif

  assign x_rx       = x_q;
  assign y_rx       = y_q;
  assign de_rx      = de_q;
  assign locked     = locked_q;
  assign h_err      = h_err_q;
  assign v_err      = v_err_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Self-checking bench for vga_rx_monitor on a reduced raster: scenario table, spot-check table,
// hand-written reset/checksum sequences and a randomized stream scored against a reference model.

module tb_vga_rx_monitor;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;
  localparam int VA = 6;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int NEG = 1;
  localparam int LF = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_tick;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb;
  logic [9:0]  x_rx;
  logic [9:0]  y_rx;
  logic        de_rx;
  logic        locked;
  logic        h_err;
  logic        v_err;
  logic        frame_done;
  logic [15:0] frame_sum;

  always #5 clk = ~clk;

  vga_rx_monitor #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_NEG(NEG), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .reset(reset), .pix_tick(pix_tick),
    .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .x_rx(x_rx), .y_rx(y_rx), .de_rx(de_rx), .locked(locked),
    .h_err(h_err), .v_err(v_err), .frame_done(frame_done), .frame_sum(frame_sum)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int fd_cnt  = 0;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model: positions as integers, lock as a run of good frames ----------------
  int          m_hpos, m_vpos, m_run;
  bit          m_hprev, m_vprev, m_hseen, m_vseen, m_vpend, m_fbad, m_herr, m_verr;
  logic [11:0] m_pix[$];
  logic [9:0]  e_x, e_y;
  bit          e_de, e_lock, e_fd;
  logic [15:0] e_sum;
  bit          m_valid = 1'b0;
  bit          last_tick = 1'b0;

  task automatic model_reset();
    m_hpos = 0; m_vpos = 0; m_run = 0;
    m_hprev = 0; m_vprev = 0; m_hseen = 0; m_vseen = 0; m_vpend = 0;
    m_fbad = 0; m_herr = 0; m_verr = 0;
    m_pix.delete();
    e_x = '0; e_y = '0; e_de = 0; e_lock = 0; e_fd = 0; e_sum = '0;
  endtask

  task automatic model_step(bit hs, bit vs, logic [11:0] c);
    bit he, ve, bnd, rep, hmis, vmis;
    logic [15:0] s;
    he = hs && !m_hprev;
    ve = vs && !m_vprev;
    m_hprev = hs;
    m_vprev = vs;
    hmis = he && m_hseen && (m_hpos + 1 != HT);
    bnd  = he && (m_vpend || ve);
    rep  = bnd && m_vseen;
    vmis = rep && (m_vpos + 1 != VT);
    e_fd = rep;
    if (he) m_hseen = 1;
    if (hmis) begin m_herr = 1; m_run = 0; m_fbad = 1; end
    if (vmis) begin m_verr = 1; m_run = 0; end
    if (rep) begin
      if (!m_fbad && !vmis) m_run++;
`ifdef RX_CHECKSUM_EN
      s = '0;
      foreach (m_pix[k]) s = {s[14:0], s[15]} ^ {4'b0000, m_pix[k]};
      e_sum = s;
`else
      s = '0;
      e_sum = s;
`endif
    end
    if (bnd) begin
      m_fbad = 0; m_vseen = 1; m_vpend = 0; m_vpos = 0;
      m_pix.delete();
    end else begin
      if (ve) m_vpend = 1;
      if (he) m_vpos = (m_vpos >= 1023) ? 1023 : m_vpos + 1;
    end
    m_hpos = he ? 0 : ((m_hpos >= 1023) ? 1023 : m_hpos + 1);
    e_de = m_vseen && (m_hpos >= HS + HB) && (m_hpos < HS + HB + HA)
                   && (m_vpos >= VS + VB) && (m_vpos < VS + VB + VA);
    e_x = e_de ? 10'(m_hpos - (HS + HB)) : 10'd0;
    e_y = e_de ? 10'(m_vpos - (VS + VB)) : 10'd0;
    if (e_de) m_pix.push_back(c);
    e_lock = (m_run >= LF);
  endtask

  always @(posedge clk) begin
    if (reset) begin
      model_reset();
      m_valid   = 1'b1;
      last_tick = 1'b0;
    end else begin
      last_tick = pix_tick;
      if (pix_tick) model_step((NEG != 0) ? !hsync : hsync, (NEG != 0) ? !vsync : vsync, rgb);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_stream",
            {x_rx, y_rx, de_rx, locked, h_err, v_err, frame_done, frame_sum},
            {e_x, e_y, e_de, e_lock, m_herr, m_verr, e_fd && last_tick, e_sum});
      if (frame_done) fd_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  bit rand_gap = 1'b0;
  int cmode    = 0;
  bit sweep_on = 1'b0;

  typedef struct {
    int line; int pix; bit de; int x; int y;
  } spot_t;
  spot_t spots[8];

  typedef struct {
    int frames; int bad_frame; int bad_len; int last_lines;
    bit e_herr; bit e_verr; bit e_lock; int e_fd;
  } scen_t;
  scen_t scens[7];

  function automatic logic [11:0] pix_color(int line, int p);
    if (cmode == 1) return (line == VS + VB + VA - 1 && p == HS + HB + HA - 1) ? 12'h001 : 12'h000;
    return 12'($urandom);
  endfunction

  task automatic send_pix(bit hs_a, bit vs_a, logic [11:0] c);
    int g;
    hsync    = (NEG != 0) ? !hs_a : hs_a;
    vsync    = (NEG != 0) ? !vs_a : vs_a;
    rgb      = c;
    pix_tick = 1'b1;
    @(negedge clk);
    pix_tick = 1'b0;
    g = rand_gap ? int'($urandom_range(0, 3)) : 3;
    repeat (g) @(negedge clk);
  endtask

  task automatic send_line(int len, int line, int p0);
    for (int p = p0; p < len; p++) begin
      send_pix(p < HS, line < VS, pix_color(line, p));
      if (sweep_on) begin
        for (int i = 0; i < 8; i++) begin
          if (spots[i].line == line && spots[i].pix == p)
            check($sformatf("spot%0d_de_x_y", i), {de_rx, x_rx, y_rx},
                  {spots[i].de, 10'(spots[i].x), 10'(spots[i].y)});
        end
      end
    end
  endtask

  task automatic send_frame(int lines, int bad_line, int bad_len, int first_line, int first_p);
    for (int l = first_line; l < lines; l++)
      send_line((l == bad_line) ? bad_len : HT, l, (l == first_line) ? first_p : 0);
  endtask

  // First pixel of the next frame: closes the current one at its sync edges.
  task automatic tail();
    send_pix(1'b1, 1'b1, pix_color(0, 0));
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    pix_tick = 1'b0;
    @(negedge clk);
    reset  = 1'b0;
    fd_cnt = 0;
    #1;
    check("reset_outputs", {x_rx, y_rx, de_rx, locked, h_err, v_err, frame_done, frame_sum}, 64'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] exp_sum;
    int lines, bl, blen;
    reset    = 1'b1;
    pix_tick = 1'b0;
    hsync    = (NEG != 0) ? 1'b1 : 1'b0;
    vsync    = (NEG != 0) ? 1'b1 : 1'b0;
    rgb      = '0;

    spots[0] = '{VS + VB,          HS + HB,          1'b1, 0,      0};
    spots[1] = '{VS + VB + VA - 1, HS + HB + HA - 1, 1'b1, HA - 1, VA - 1};
    spots[2] = '{VS + VB,          HS + HB - 1,      1'b0, 0,      0};
    spots[3] = '{VS + VB,          HS + HB + HA,     1'b0, 0,      0};
    spots[4] = '{VS + VB + 1,      0,                1'b0, 0,      0};
    spots[5] = '{VS,               HS + HB,          1'b0, 0,      0};
    spots[6] = '{VS + VB + VA,     HS + HB,          1'b0, 0,      0};
    spots[7] = '{VS + VB + 2,      HS + HB + 3,      1'b1, 3,      2};

    //            frames bad_f bad_len  last_lines h  v  lock fd
    scens[0] = '{2,     -1,   0,       VT,        0, 0, 1,   2};
    scens[1] = '{1,     -1,   0,       VT,        0, 0, 0,   1};
    scens[2] = '{3,      0,   HT - 1,  VT,        1, 0, 1,   3};
    scens[3] = '{2,      1,   HT - 1,  VT,        1, 0, 0,   2};
    scens[4] = '{2,     -1,   0,       VT - 1,    0, 1, 0,   2};
    scens[5] = '{3,     -1,   0,       VT + 1,    0, 1, 0,   3};
    scens[6] = '{3,      2,   HT + 1,  VT,        1, 0, 0,   3};

    repeat (2) @(negedge clk);

`ifdef RX_CHECKSUM_EN
    exp_sum = 16'h0001;
`else
    exp_sum = 16'h0000;
`endif

    // Scenario table: each entry starts from reset and ends with a closing boundary.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      for (int f = 0; f < scens[i].frames; f++)
        send_frame((f == scens[i].frames - 1) ? scens[i].last_lines : VT,
                   (f == scens[i].bad_frame) ? 4 : -1, scens[i].bad_len, 0, 0);
      tail();
      check($sformatf("scen%0d_h_err", i), h_err, scens[i].e_herr);
      check($sformatf("scen%0d_v_err", i), v_err, scens[i].e_verr);
      check($sformatf("scen%0d_locked", i), locked, scens[i].e_lock);
      check($sformatf("scen%0d_frame_done_count", i), fd_cnt, scens[i].e_fd);
    end

    // Nominal lock, positional sweep and single-pixel checksum.
    do_reset();
    cmode = 1;
    send_frame(VT, -1, 0, 0, 0);
    send_frame(VT, -1, 0, 0, 0);
    tail();
    check("nominal_locked", locked, 1'b1);
    check("nominal_errs", {h_err, v_err}, 2'b00);
    check("nominal_fd_count", fd_cnt, 2);
    check("checksum_a", frame_sum, exp_sum);
    sweep_on = 1'b1;
    send_frame(VT, -1, 0, 0, 1);
    sweep_on = 1'b0;
    tail();
    check("checksum_b", frame_sum, exp_sum);
    check("sweep_locked", locked, 1'b1);
    cmode = 0;

    // Reset for one clk in the middle of an active line.
    do_reset();
    send_frame(VT, -1, 0, 0, 0);
    send_frame(VT, -1, 0, 0, 0);
    send_frame(6, -1, 0, 0, 0);
    send_line(HS + HB + 4, 6, 0);
    do_reset();
    send_line(HT, 6, HS + HB + 4);
    send_frame(VT, -1, 0, 7, 0);
    tail();
    check("midreset_first_boundary_fd", fd_cnt, 0);
    check("midreset_first_boundary_lock", locked, 1'b0);
    send_frame(VT, -1, 0, 0, 1);
    tail();
    check("midreset_second_boundary_fd", fd_cnt, 1);
    check("midreset_second_boundary_lock", locked, 1'b0);
    send_frame(VT, -1, 0, 0, 1);
    tail();
    check("midreset_relock", locked, 1'b1);
    check("midreset_errs", {h_err, v_err}, 2'b00);

    // Randomized stream: irregular ticks, random colours, occasional bad lines and frames.
    do_reset();
    rand_gap = 1'b1;
    for (int f = 0; f < 25; f++) begin
      lines = VT;
      if ($urandom_range(0, 4) == 0) lines = ($urandom_range(0, 1) == 0) ? VT - 1 : VT + 1;
      bl   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, VT - 2)) : -1;
      blen = HT + int'($urandom_range(0, 3)) - 2;
      if (blen == HT) blen = HT + 2;
      send_frame(lines, bl, blen, 0, 0);
    end
    tail();
    rand_gap = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
